// File: rtl/lcd_pkg.sv
// Shared constants, state encoding and byte helpers for the LCD frame scheduler.
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_LINE1 = 8'h80;
    localparam logic [7:0] LCD_CMD_LINE2 = 8'hC0;
    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_COLON   = 8'h3A;

    localparam int unsigned TIME_LEN = 5;
    localparam int unsigned CNT_W    = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GRANT = 3'd1,
        ST_CMD   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_LOAD  = 3'd4,
        ST_CHAR  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    typedef enum logic {
        SRC_NAME = 1'b0,
        SRC_TIME = 1'b1
    } src_t;

    // One BCD digit to ASCII; digits above 9 are passed through unchecked.
    function automatic logic [7:0] bcd_ascii(input logic [3:0] digit);
        return ASCII_ZERO + {4'h0, digit};
    endfunction

    // Character at position idx of the "mm:ss" line built from {m10,m1,s10,s1}.
    function automatic logic [7:0] time_char(input logic [15:0] bcd,
                                             input logic [CNT_W-1:0] idx);
        logic [7:0] ch;
        case (idx)
            5'd0:    ch = bcd_ascii(bcd[15:12]);
            5'd1:    ch = bcd_ascii(bcd[11:8]);
            5'd2:    ch = ASCII_COLON;
            5'd3:    ch = bcd_ascii(bcd[7:4]);
            default: ch = bcd_ascii(bcd[3:0]);
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/lcd_rr_arb2.sv
// Two-request round-robin arbiter: bit 0 = NAME source, bit 1 = TIME source.
module lcd_rr_arb2 import lcd_pkg::*; (
    input  logic [1:0] pend,
    input  src_t       last_src,
    output logic [1:0] grant_c
);

    // A lone request wins outright; on a tie the source not served last wins.
    always_comb begin
        grant_c = pend;
        if (pend == 2'b11) begin
            grant_c = (last_src == SRC_TIME) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/lcd_frame_scheduler.sv
// Shares one LCD character driver between the exercise-name line and the countdown line.
module lcd_frame_scheduler import lcd_pkg::*; #(
    parameter int unsigned NAME_LEN = 16,
    parameter int unsigned GAP_CYC  = 40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        name_req,
    input  logic        time_req,
    input  logic [15:0] time_bcd,
    output logic [4:0]  name_idx,
    input  logic [7:0]  name_char,
    input  logic        drv_busy,
    output logic        drv_we,
    output logic        drv_rs,
    output logic [7:0]  drv_data,
    output logic        frame_busy,
    output logic        frame_done
);

    localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

    state_t             state;
    src_t               src;
    src_t               last_src;
    logic               name_pend;
    logic               time_pend;
    logic               wait_first;
    logic [15:0]        snap;
    logic [CNT_W-1:0]   cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [1:0]         grant_c;
    logic [CNT_W-1:0]   frame_len_c;
    logic [7:0]         char_byte_c;

    lcd_rr_arb2 u_arb (
        .pend     ({time_pend, name_pend}),
        .last_src (last_src),
        .grant_c  (grant_c)
    );

    // Byte count of the active frame and the character to send at position cnt.
    always_comb begin
        frame_len_c = (src == SRC_TIME) ? CNT_W'(TIME_LEN) : CNT_W'(NAME_LEN);
        char_byte_c = (src == SRC_TIME) ? time_char(snap, cnt) : name_char;
    end

    // Pending flags: any request sets, a grant clears; a request on the grant cycle wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            name_pend <= 1'b1;
            time_pend <= 1'b1;
        end else begin
            name_pend <= name_req | (name_pend & ~((state == ST_GRANT) & grant_c[0]));
            time_pend <= time_req | (time_pend & ~((state == ST_GRANT) & grant_c[1]));
        end
    end

    // Frame sequencer: command byte, then characters, each paced by busy and the gap counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            src        <= SRC_NAME;
            last_src   <= SRC_TIME;
            wait_first <= 1'b0;
            snap       <= '0;
            cnt        <= '0;
            gap_cnt    <= '0;
            name_idx   <= '0;
            drv_we     <= 1'b0;
            drv_rs     <= 1'b0;
            drv_data   <= '0;
            frame_busy <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            drv_we     <= 1'b0;
            frame_done <= 1'b0;
            if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if ((name_pend | time_pend) && !drv_busy && (gap_cnt == '0)) begin
                        frame_busy <= 1'b1;
                        state      <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    src      <= grant_c[1] ? SRC_TIME : SRC_NAME;
                    snap     <= time_bcd;
                    cnt      <= '0;
                    drv_we   <= 1'b1;
                    drv_rs   <= 1'b0;
                    drv_data <= grant_c[1] ? LCD_CMD_LINE2 : LCD_CMD_LINE1;
                    gap_cnt  <= GAP_W'(GAP_CYC);
                    state    <= ST_CMD;
                end
                ST_CMD: begin
                    wait_first <= 1'b1;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    // The driver may not have raised busy yet in the first cycle after a strobe.
                    if (wait_first) begin
                        wait_first <= 1'b0;
                    end else if (!drv_busy && (gap_cnt == '0)) begin
                        if (cnt == frame_len_c) begin
                            frame_done <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            name_idx <= cnt;
                            state    <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    drv_we   <= 1'b1;
                    drv_rs   <= 1'b1;
                    drv_data <= char_byte_c;
                    gap_cnt  <= GAP_W'(GAP_CYC);
                    state    <= ST_CHAR;
                end
                ST_CHAR: begin
                    cnt        <= cnt + CNT_W'(1);
                    wait_first <= 1'b1;
                    state      <= ST_WAIT;
                end
                ST_DONE: begin
                    last_src   <= src;
                    frame_busy <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
